// File: rtl/axi_sys_bus_bridge.sv
// AXI4 single-beat slave bridging to the internal system register bus.
// Bursts are drained and answered with SLVERR; bus accesses time out after 2^TW cycles.
module axi_sys_bus_bridge #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int IW = 4,
    parameter int LW = 4,
    parameter int TW = 5
) (
    input  logic            aclk_i,
    input  logic            arst_i,
    input  logic [IW-1:0]   awid_i,
    input  logic [LW-1:0]   awlen_i,
    input  logic [AW-1:0]   awaddr_i,
    input  logic            awvalid_i,
    output logic            awready_o,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic            wvalid_i,
    output logic            wready_o,
    output logic [IW-1:0]   bid_o,
    output logic [1:0]      bresp_o,
    output logic            bvalid_o,
    input  logic            bready_i,
    input  logic [IW-1:0]   arid_i,
    input  logic [LW-1:0]   arlen_i,
    input  logic [AW-1:0]   araddr_i,
    input  logic            arvalid_i,
    output logic            arready_o,
    output logic [IW-1:0]   rid_o,
    output logic [DW-1:0]   rdata_o,
    output logic [1:0]      rresp_o,
    output logic            rlast_o,
    output logic            rvalid_o,
    input  logic            rready_i,
    output logic [AW-1:0]   sys_addr_o,
    output logic [DW-1:0]   sys_wdata_o,
    output logic [DW/8-1:0] sys_sel_o,
    output logic            sys_wen_o,
    output logic            sys_ren_o,
    input  logic [DW-1:0]   sys_rdata_i,
    input  logic            sys_err_i,
    input  logic            sys_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_ACC, S_W_DRAIN, S_W_BUS, S_W_RESP, S_R_ACC, S_R_BUS, S_R_RESP
    } state_t;

    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;
    localparam logic [TW-1:0] TMO_MAX     = '1;

    state_t        state, state_n;
    logic [LW-1:0] beat, beat_n;   // beats still to move after the current one
    logic [TW-1:0] tmo_cnt;
    logic          in_bus, tmo_hit, bus_done;
    logic [1:0]    bus_resp;

    assign in_bus   = (state == S_W_BUS) || (state == S_R_BUS);
    assign tmo_hit  = (tmo_cnt == TMO_MAX);
    assign bus_done = sys_ack_i || tmo_hit;
    // An ack coinciding with the timeout still reports the slave's own status.
    assign bus_resp = (sys_ack_i && !sys_err_i) ? RESP_OKAY : RESP_SLVERR;

    always_comb begin
        // NOTE: defaults first so every path assigns state_n/beat_n and no latch is inferred.
        state_n = state;
        beat_n  = beat;
        case (state)
            S_IDLE: begin
                if (awvalid_i && wvalid_i) state_n = S_W_ACC;
                else if (arvalid_i)        state_n = S_R_ACC;
            end
            S_W_ACC: begin
                beat_n  = awlen_i;
                state_n = (awlen_i == '0) ? S_W_BUS : S_W_DRAIN;
            end
            S_W_DRAIN: begin
                if (wvalid_i) begin
                    beat_n = beat - LW'(1);
                    if (beat_n == '0) state_n = S_W_RESP;
                end
            end
            S_W_BUS:  if (bus_done) state_n = S_W_RESP;
            S_W_RESP: if (bready_i) state_n = S_IDLE;
            S_R_ACC: begin
                beat_n  = arlen_i;
                state_n = (arlen_i == '0) ? S_R_BUS : S_R_RESP;
            end
            S_R_BUS:  if (bus_done) state_n = S_R_RESP;
            S_R_RESP: begin
                if (rready_i) begin
                    if (beat == '0) state_n = S_IDLE;
                    else            beat_n  = beat - LW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs are registered from the next state so they
    // line up exactly with the state they belong to.
    always_ff @(posedge aclk_i) begin
        if (arst_i) begin
            state       <= S_IDLE;
            beat        <= '0;
            tmo_cnt     <= '0;
            awready_o   <= 1'b0;
            wready_o    <= 1'b0;
            arready_o   <= 1'b0;
            bvalid_o    <= 1'b0;
            rvalid_o    <= 1'b0;
            rlast_o     <= 1'b0;
            sys_wen_o   <= 1'b0;
            sys_ren_o   <= 1'b0;
            bresp_o     <= RESP_OKAY;
            rresp_o     <= RESP_OKAY;
            bid_o       <= '0;
            rid_o       <= '0;
            rdata_o     <= '0;
            sys_addr_o  <= '0;
            sys_wdata_o <= '0;
            sys_sel_o   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= state_n;
            beat  <= beat_n;

            if ((state_n == S_W_BUS || state_n == S_R_BUS) && state_n != state)
                tmo_cnt <= '0;
            else if (in_bus && !sys_ack_i)
                tmo_cnt <= tmo_cnt + TW'(1);

            awready_o <= (state_n == S_W_ACC);
            wready_o  <= (state_n == S_W_ACC) || (state_n == S_W_DRAIN);
            arready_o <= (state_n == S_R_ACC);
            bvalid_o  <= (state_n == S_W_RESP);
            rvalid_o  <= (state_n == S_R_RESP);
            rlast_o   <= (state_n == S_R_RESP) && (beat_n == '0);
            sys_wen_o <= (state_n == S_W_BUS) && (state != S_W_BUS);
            sys_ren_o <= (state_n == S_R_BUS) && (state != S_R_BUS);

            case (state)
                S_W_ACC: begin
                    bid_o       <= awid_i;
                    sys_addr_o  <= awaddr_i;
                    sys_wdata_o <= wdata_i;
                    sys_sel_o   <= wstrb_i;
                    bresp_o     <= (awlen_i == '0) ? RESP_OKAY : RESP_SLVERR;
                end
                S_W_BUS: if (bus_done) bresp_o <= bus_resp;
                S_R_ACC: begin
                    rid_o      <= arid_i;
                    sys_addr_o <= araddr_i;
                    sys_sel_o  <= '1;
                    rdata_o    <= '0;
                    rresp_o    <= (arlen_i == '0) ? RESP_OKAY : RESP_SLVERR;
                end
                S_R_BUS: begin
                    if (bus_done) begin
                        rdata_o <= sys_ack_i ? sys_rdata_i : '0;
                        rresp_o <= bus_resp;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sys_bus_bridge.sv
// Directed self-checking bench for axi_sys_bus_bridge: single accesses, bursts,
// timeout boundary, write/read arbitration and mid-transaction reset.
module tb_axi_sys_bus_bridge;

    logic        aclk_i = 1'b0;
    logic        arst_i;
    logic [3:0]  awid_i, arid_i, bid_o, rid_o;
    logic [3:0]  awlen_i, arlen_i;
    logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o, sys_addr_o, sys_wdata_o, sys_rdata_i;
    logic [3:0]  wstrb_i, sys_sel_o;
    logic        awvalid_i, awready_o, wvalid_i, wready_o, bvalid_o, bready_i;
    logic        arvalid_i, arready_o, rvalid_o, rready_i, rlast_o;
    logic [1:0]  bresp_o, rresp_o;
    logic        sys_wen_o, sys_ren_o, sys_err_i, sys_ack_i;

    int n_tests = 0;
    int n_fail  = 0;
    int wen_cnt = 0, ren_cnt = 0, whs_cnt = 0;

    localparam int SIG_AWREADY = 0, SIG_ARREADY = 1, SIG_WEN = 2, SIG_REN = 3,
                   SIG_BVALID  = 4, SIG_RVALID  = 5;

    axi_sys_bus_bridge dut (
        .aclk_i(aclk_i), .arst_i(arst_i),
        .awid_i(awid_i), .awlen_i(awlen_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .arlen_i(arlen_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
        .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
        .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i)
    );

    always #5 aclk_i = ~aclk_i;

    always @(negedge aclk_i) begin
        if (sys_wen_o) wen_cnt++;
        if (sys_ren_o) ren_cnt++;
        if (wready_o && wvalid_i) whs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk_i);
        #1;
    endtask

    function automatic logic sig(input int k);
        case (k)
            SIG_AWREADY: return awready_o;
            SIG_ARREADY: return arready_o;
            SIG_WEN:     return sys_wen_o;
            SIG_REN:     return sys_ren_o;
            SIG_BVALID:  return bvalid_o;
            default:     return rvalid_o;
        endcase
    endfunction

    task automatic wait_sig(input int k, input string tag, output int n);
        n = 0;
        while (sig(k) !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (sig(k) !== 1'b1) check({tag, " wait expired"}, sig(k), 1);
    endtask

    int n, beats, wen0, ren0, whs0;
    logic flag;

    initial begin
        arst_i = 1; awid_i = 0; arid_i = 0; awlen_i = 0; arlen_i = 0; awaddr_i = 0; araddr_i = 0;
        wdata_i = 0; wstrb_i = 0; awvalid_i = 0; wvalid_i = 0; bready_i = 0; arvalid_i = 0;
        rready_i = 0; sys_rdata_i = 0; sys_err_i = 0; sys_ack_i = 0;

        // Reset state
        tick(); tick();
        check("rst ready/valid/strobe", {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, rlast_o, sys_wen_o, sys_ren_o}, 0);
        check("rst resp/ids/sel", {bresp_o, rresp_o, bid_o, rid_o, sys_sel_o}, 0);
        check("rst sys addr/wdata", {sys_addr_o, sys_wdata_o}, 0);
        check("rst rdata", rdata_o, 0);
        arst_i = 0;
        tick();

        // Single write, ack in the strobe cycle
        awid_i = 3; awlen_i = 0; awaddr_i = 32'h4000_0010; wdata_i = 32'hDEAD_BEEF; wstrb_i = 4'hF;
        awvalid_i = 1; wvalid_i = 1;
        tick();
        check("wr t1 aw/w ready", {awready_o, wready_o, arready_o}, 3'b110);
        check("wr t1 no strobe", sys_wen_o, 0);
        tick();
        awvalid_i = 0; wvalid_i = 0;
        check("wr t2 wen", sys_wen_o, 1);
        check("wr t2 readies dropped", {awready_o, wready_o}, 0);
        check("wr addr/data", {sys_addr_o, sys_wdata_o}, {32'h4000_0010, 32'hDEAD_BEEF});
        check("wr sel", sys_sel_o, 4'hF);
        sys_ack_i = 1;
        tick();
        sys_ack_i = 0;
        check("wr t3 bvalid", bvalid_o, 1);
        check("wr t3 wen single cycle", sys_wen_o, 0);
        check("wr bid/bresp", {bid_o, bresp_o}, {4'd3, 2'b00});
        bready_i = 1;
        tick();
        bready_i = 0;
        check("wr bvalid dropped", bvalid_o, 0);

        // Single read, ack four cycles after the strobe
        ren0 = ren_cnt;
        arid_i = 4'hA; arlen_i = 0; araddr_i = 32'h4000_0020; arvalid_i = 1;
        tick();
        check("rd t1 arready", arready_o, 1);
        tick();
        arvalid_i = 0;
        check("rd t2 ren", sys_ren_o, 1);
        check("rd addr/sel", {sys_addr_o, sys_sel_o}, {32'h4000_0020, 4'hF});
        flag = 0;
        repeat (3) begin
            tick();
            if (rvalid_o !== 1'b0 || sys_addr_o !== 32'h4000_0020) flag = 1;
        end
        check("rd wait: no rvalid, addr stable", flag, 0);
        tick();
        sys_ack_i = 1; sys_rdata_i = 32'h1234_5678;
        tick();
        sys_ack_i = 0; sys_rdata_i = 0;
        check("rd rvalid", rvalid_o, 1);
        check("rd rid/rresp/rlast/rdata", {rid_o, rresp_o, rlast_o, rdata_o}, {4'hA, 2'b00, 1'b1, 32'h1234_5678});
        check("rd one ren pulse", ren_cnt - ren0, 1);
        rready_i = 1;
        tick();
        rready_i = 0;
        check("rd rvalid dropped", rvalid_o, 0);

        // Write burst awlen=3: drained, no bus access, SLVERR
        wen0 = wen_cnt; whs0 = whs_cnt;
        awid_i = 6; awlen_i = 3; awaddr_i = 32'h4000_0030; wdata_i = 32'h1; wstrb_i = 4'hF;
        awvalid_i = 1; wvalid_i = 1;
        wait_sig(SIG_AWREADY, "wburst aw", n);
        tick();
        awvalid_i = 0;
        wait_sig(SIG_BVALID, "wburst b", n);
        wvalid_i = 0;
        check("wburst w beats", whs_cnt - whs0, 4);
        check("wburst no wen", wen_cnt - wen0, 0);
        check("wburst bid/bresp", {bid_o, bresp_o}, {4'd6, 2'b10});
        bready_i = 1;
        tick();
        bready_i = 0;

        // Read burst arlen=2: three SLVERR beats, rlast on the third
        ren0 = ren_cnt;
        arid_i = 9; arlen_i = 2; araddr_i = 32'h4000_0040; arvalid_i = 1;
        wait_sig(SIG_ARREADY, "rburst ar", n);
        tick();
        arvalid_i = 0;
        wait_sig(SIG_RVALID, "rburst r", n);
        rready_i = 1;
        beats = 0;
        for (int i = 0; i < 8 && rvalid_o === 1'b1; i++) begin
            beats++;
            check($sformatf("rburst rlast beat%0d", beats), rlast_o, beats == 3);
            check($sformatf("rburst resp/id/data beat%0d", beats), {rresp_o, rid_o, rdata_o}, {2'b10, 4'd9, 32'h0});
            tick();
        end
        rready_i = 0;
        check("rburst beat count", beats, 3);
        check("rburst no ren", ren_cnt - ren0, 0);

        // Ack on cycle 31 after the strobe beats the timeout
        arid_i = 1; arlen_i = 0; araddr_i = 32'h4000_0100; arvalid_i = 1;
        wait_sig(SIG_REN, "ack31 ren", n);
        arvalid_i = 0;
        flag = 0;
        repeat (31) begin
            tick();
            if (rvalid_o !== 1'b0) flag = 1;
        end
        check("ack31 no early rvalid", flag, 0);
        sys_ack_i = 1; sys_rdata_i = 32'hCAFE_F00D;
        tick();
        sys_ack_i = 0; sys_rdata_i = 32'hFFFF_FFFF;
        check("ack31 rvalid", rvalid_o, 1);
        check("ack31 resp/data", {rresp_o, rdata_o}, {2'b00, 32'hCAFE_F00D});
        rready_i = 1;
        tick();
        rready_i = 0;

        // No ack: SLVERR with zero data exactly 32 cycles after the strobe
        arid_i = 2; araddr_i = 32'h4000_0104; arvalid_i = 1;
        wait_sig(SIG_REN, "tmo ren", n);
        arvalid_i = 0;
        n = 0;
        while (rvalid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("tmo latency", n, 32);
        check("tmo resp/data", {rresp_o, rdata_o}, {2'b10, 32'h0});
        rready_i = 1;
        tick();
        rready_i = 0;
        sys_rdata_i = 0;

        // AW, W and AR together: write first, bready held low, then the read
        awid_i = 1; awlen_i = 0; awaddr_i = 32'h4000_0200; wdata_i = 32'h0000_00A5; wstrb_i = 4'h5;
        awvalid_i = 1; wvalid_i = 1;
        arid_i = 2; arlen_i = 0; araddr_i = 32'h4000_0300; arvalid_i = 1;
        tick();
        check("tie write wins", {awready_o, wready_o, arready_o}, 3'b110);
        tick();
        awvalid_i = 0; wvalid_i = 0;
        check("tie wen/sel", {sys_wen_o, sys_sel_o}, {1'b1, 4'h5});
        sys_ack_i = 1; sys_err_i = 1;
        tick();
        sys_ack_i = 0; sys_err_i = 0;
        check("tie bvalid/bresp err", {bvalid_o, bresp_o}, {1'b1, 2'b10});
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("tie hold%0d bvalid/arready", i), {bvalid_o, arready_o}, 2'b10);
        end
        bready_i = 1;
        tick();
        bready_i = 0;
        check("tie after b", {bvalid_o, arready_o}, 2'b00);
        tick();
        check("tie read arready", arready_o, 1);
        tick();
        arvalid_i = 0;
        check("tie read ren/addr", {sys_ren_o, sys_addr_o}, {1'b1, 32'h4000_0300});
        sys_ack_i = 1; sys_rdata_i = 32'h0BAD_F00D;
        tick();
        sys_ack_i = 0; sys_rdata_i = 0;
        check("tie read rvalid/rid/resp/data", {rvalid_o, rid_o, rresp_o, rdata_o}, {1'b1, 4'd2, 2'b00, 32'h0BAD_F00D});
        rready_i = 1;
        tick();
        rready_i = 0;

        // Reset during W_BUS aborts; late ack in IDLE ignored; next read works
        wen0 = wen_cnt;
        awid_i = 7; awlen_i = 0; awaddr_i = 32'h4000_0400; wdata_i = 32'h1111_2222; wstrb_i = 4'hF;
        awvalid_i = 1; wvalid_i = 1;
        wait_sig(SIG_WEN, "mrst wen", n);
        awvalid_i = 0; wvalid_i = 0;
        arst_i = 1;
        tick();
        arst_i = 0;
        check("mrst ready/valid/strobe", {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, rlast_o, sys_wen_o, sys_ren_o}, 0);
        check("mrst sys addr/wdata", {sys_addr_o, sys_wdata_o}, 0);
        check("mrst resp/ids/sel", {bid_o, rid_o, bresp_o, rresp_o, sys_sel_o}, 0);
        sys_ack_i = 1; sys_err_i = 1;
        flag = 0;
        repeat (3) begin
            tick();
            if ({bvalid_o, rvalid_o, sys_wen_o, sys_ren_o} !== 4'b0) flag = 1;
        end
        sys_ack_i = 0; sys_err_i = 0;
        check("late ack ignored", flag, 0);
        check("mrst single wen pulse", wen_cnt - wen0, 1);
        arid_i = 3; arlen_i = 0; araddr_i = 32'h4000_0500; arvalid_i = 1;
        tick();
        check("post-rst arready", arready_o, 1);
        tick();
        arvalid_i = 0;
        check("post-rst ren", sys_ren_o, 1);
        sys_ack_i = 1; sys_rdata_i = 32'h5555_AAAA;
        tick();
        sys_ack_i = 0; sys_rdata_i = 0;
        check("post-rst read", {rvalid_o, rid_o, rresp_o, rlast_o, rdata_o}, {1'b1, 4'd3, 2'b00, 1'b1, 32'h5555_AAAA});
        rready_i = 1;
        tick();
        rready_i = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_sys_bus_bridge.md
# axi_sys_bus_bridge
AXI4 single-beat slave that sits directly downstream of the AXI master port (PS GP port in hardware, the AXI master model in simulation). It converts each accepted read or write into one access on the internal system register bus, waits for acknowledge or timeout, and returns the AXI response. Bursts are rejected with SLVERR and fully drained, so a misbehaving master can never hang the interconnect.
## Interface
- AW, 32: address width (AXI and sys bus)
- DW, 32: data width; strobe width DW/8
- IW, 4: AXI ID width
- LW, 4: AxLEN width
- TW, 5: timeout counter width; timeout = 2^TW cycles
- aclk_i in 1: clock
- arst_i in 1: synchronous reset, active-high
- awid_i in IW: write ID
- awlen_i in LW: write burst length - 1
- awaddr_i in AW: write address
- awvalid_i in 1: write address valid
- awready_o out 1: write address ready
- wdata_i in DW: write data
- wstrb_i in DW/8: byte strobes
- wvalid_i in 1: write data valid
- wready_o out 1: write data ready
- bid_o out IW: response ID (captured awid)
- bresp_o out 2: 00 OKAY, 10 SLVERR
- bvalid_o out 1: write response valid
- bready_i in 1: write response ready
- arid_i in IW: read ID
- arlen_i in LW: read burst length - 1
- araddr_i in AW: read address
- arvalid_i in 1: read address valid
- arready_o out 1: read address ready
- rid_o out IW: read ID (captured arid)
- rdata_o out DW: read data
- rresp_o out 2: 00 OKAY, 10 SLVERR
- rlast_o out 1: last read beat
- rvalid_o out 1: read data valid
- rready_i in 1: read data ready
- sys_addr_o out AW: sys bus address (captured AXI address, unmodified)
- sys_wdata_o out DW: sys bus write data
- sys_sel_o out DW/8: byte enables (wstrb on write, all ones on read)
- sys_wen_o out 1: one-cycle write strobe
- sys_ren_o out 1: one-cycle read strobe
- sys_rdata_i in DW: read data, valid with sys_ack_i
- sys_err_i in 1: error, valid with sys_ack_i
- sys_ack_i in 1: access complete
## Operation
- FSM states: IDLE, W_ACC, W_DRAIN, W_BUS, W_RESP, R_ACC, R_BUS, R_RESP. One transaction in flight; all outputs registered.
- IDLE: all readies/valids 0. awvalid_i&wvalid_i -> W_ACC (write wins a tie with arvalid_i); else arvalid_i -> R_ACC. awvalid_i without wvalid_i waits in IDLE.
- W_ACC: awready_o=wready_o=1 for exactly one cycle; capture id, len, addr, data, strb. len==0 -> W_BUS; len!=0 -> W_DRAIN with resp latched SLVERR, beat counter = len.
- W_DRAIN: wready_o=1; decrement on each wvalid_i; at 0 -> W_RESP. No sys bus access. wlast is not checked; beat count is taken from awlen.
- W_BUS: sys_wen_o high on first cycle only; wait for sys_ack_i -> W_RESP, bresp = sys_err_i ? SLVERR : OKAY.
- W_RESP: bvalid_o=1 held until bready_i; then IDLE.
- R_ACC: arready_o=1 one cycle; capture id, len, addr. len==0 -> R_BUS. len!=0 -> R_RESP with len+1 beats, rdata_o=0, rresp_o=SLVERR, no bus access.
- R_BUS: sys_ren_o high on first cycle; sys_ack_i -> R_RESP, rdata_o = sys_rdata_i captured, rresp from sys_err_i.
- R_RESP: rvalid_o=1; each rready_i handshake consumes a beat; rlast_o=1 on final beat only; after final beat -> IDLE.
- Timeout: counter cleared on bus-state entry, +1 per cycle without ack; reaching 2^TW-1 -> SLVERR response, rdata_o=0. An ack in the same cycle as timeout wins. A late ack arriving in IDLE is ignored.
## Timing
- Reset (arst_i sampled high at posedge): state IDLE, all valid/ready/strobe outputs 0, bresp_o/rresp_o 00, rlast_o 0, bid_o/rid_o/rdata_o/sys_* data 0. Reset mid-transaction aborts it with no response and no further sys strobe.
- Minimum latency, valid seen at cycle t0: readies at t1, sys strobe at t2, ack at t2 -> bvalid_o/rvalid_o at t3.
- sys_addr_o/sys_wdata_o/sys_sel_o are stable from strobe until ack/timeout.
## Test plan
- Write 0x40000010 = 0xDEADBEEF, strb 0xF, ack at t2 -> sys_wen_o 1 cycle with matching addr/data/sel, bvalid_o at t3, bid_o echoes awid_i=3, bresp_o=00.
- Read 0x40000020, sys_rdata_i=0x12345678 after 4-cycle ack delay -> rdata_o=0x12345678, rlast_o=1, rresp_o=00, rid_o echoes arid_i.
- awlen_i=3 write -> four wready_o beats, zero sys_wen_o pulses, bresp_o=10. arlen_i=2 read -> three beats, rlast_o on the third, rresp_o=10, zero sys_ren_o.
- No ack, TW=5 -> SLVERR response exactly 32 cycles after the strobe; an ack at cycle 31 returns OKAY instead.
- AW, W and AR valid in the same cycle -> write serviced first, then the read; bready_i held low 5 cycles -> bvalid_o held and arready_o stays 0 throughout.
- arst_i asserted during W_BUS -> all outputs 0 next cycle; a following read completes normally.
